i2c_sensor_capture: RTL and testbench
=====================================

# i2c_sensor_capture

Passive I2C bus monitor that sits upstream of the controller and preprocessor/Kalman stages. It watches the shared sensor bus (`scl`, `sda_in`, never drives it) and recognises 6-byte read bursts addressed to the accelerometer, gyroscope or magnetometer. Each recognised burst is committed into a 48-bit per-sensor holding register, and the matching `*_ready` flag is raised. The controller consumes each sample through a `*_ready`/`*_read` handshake.

## Interface
- No parameters.
- `clk` in 1: system clock; must be ≥ 8× the `scl` frequency.
- `n_rst` in 1: asynchronous, active-low reset.
- `scl` in 1: I2C clock, asynchronous to `clk`.
- `sda_in` in 1: I2C data, asynchronous to `clk`.
- `device_addr` in 21: 7-bit sensor addresses. [6:0] acc, [13:7] gyro, [20:14] mag.
- `acc_read` in 1: single-cycle pulse from the controller; clears `acc_ready`.
- `gyro_read` in 1: single-cycle pulse from the controller; clears `gyro_ready`.
- `mag_read` in 1: single-cycle pulse from the controller; clears `mag_ready`.
- `acc_ready` out 1: a committed accelerometer sample is unread.
- `gyro_ready` out 1: a committed gyroscope sample is unread.
- `mag_ready` out 1: a committed magnetometer sample is unread.
- `acc_data` out 48: {z,y,x}, 16 bits per axis.
- `gyro_data` out 48: {z,y,x}, 16 bits per axis.
- `mag_data` out 48: {z,y,x}, 16 bits per axis.
- `overrun` out 3: sticky per-sensor flags {mag,gyro,acc}. A flag sets when a commit lands while that sensor's ready is already 1. It is cleared only by reset.

## Operation
- Synchronisation: `scl` and `sda_in` each pass through 2 flops, then 1 history flop.
  - rise/fall = synced value vs history value.
  - START = sda fall while synced scl = 1.
  - STOP = sda rise while synced scl = 1.
- Bit sampling: sda is sampled on synced scl rise. Bits are MSB first. A 4-bit counter counts 0..8; count 8 is the ACK/NACK slot and is ignored.
- FSM states: IDLE, ADDR, DATA, IGNORE.
  - IDLE: waits for START → ADDR. Clears the byte counter and the 48-bit shift buffer.
  - ADDR: after 8 bits, byte = {addr[6:0], rw}.
    - If rw = 1 and addr equals one of the three fields, latch sel (acc/gyro/mag) and go to DATA after the ACK slot.
    - Otherwise go to IGNORE.
  - DATA: each completed byte is written to `buffer[8*n +: 8]`, n = byte index 0..5. Byte order is x_lo, x_hi, y_lo, y_hi, z_lo, z_hi. Bytes beyond the 6th are discarded; n saturates at 6.
  - IGNORE: waits for START or STOP.
- Address priority: if several fields match, acc > gyro > mag.
- STOP in DATA with n = 6: commit. The selected `*_data` ← buffer and `*_ready` ← 1. If that ready was already 1, set the matching `overrun` bit. Then go to IDLE.
- STOP in DATA with n < 6, or STOP in ADDR: abort with no commit → IDLE.
- START (including a repeated start) in any state: abort the current frame, no commit → ADDR.
- STOP in IDLE or IGNORE → IDLE.
- A `*_read` pulse clears that ready in the next cycle. A read while ready = 0 has no effect. Data registers hold their value after a read.
- Commit and read of the same sensor in the same cycle: commit wins. Ready stays 1, data is new, and `overrun` is set.
- Commits to different sensors are independent. Only one commit can occur per cycle.

## Timing
- Reset: all `*_ready` = 0, all `*_data` = 0, `overrun` = 0, FSM = IDLE. Counters and buffer are cleared.
- Reset asserted mid-frame discards the partial frame. After release the FSM stays in IDLE until a fresh START.
- Bus-to-internal delay: 3 `clk` edges from a raw pin edge to the detect condition (2 sync flops + history flop).
- Commit latency: `*_ready` and `*_data` update on the 4th `clk` rising edge after the raw `sda_in` STOP rise. Both update on the same edge.
- Read latency: ready is low in the cycle after the `*_read` pulse is sampled.
- Data bits are sampled exactly once per synced `scl` rise. Glitches shorter than 1 `clk` are not filtered; clk ≥ 8× scl is required.

## Test plan
- Reset and single commit:
  - Stimulus: after reset, drive START, addr 0x68 with rw = 1 (acc = 0x68), bytes 01 02 03 04 05 06, then STOP.
  - Required: `acc_ready` = 1 and `acc_data` = 0x060504030201 on the 4th clk after STOP; gyro/mag ready stay 0.
- Handshake:
  - Stimulus: pulse `acc_read`.
  - Required: `acc_ready` = 0 next cycle; `acc_data` unchanged.
  - Stimulus: pulse `gyro_read` while `gyro_ready` = 0.
  - Required: no change.
- Filtering:
  - Stimulus: unknown addr 0x50; then acc addr with rw = 0; then acc burst of 4 bytes + STOP.
  - Required: no ready asserted; data unchanged.
- Repeated start and over-length:
  - Stimulus: gyro burst interrupted after 3 bytes by repeated START to mag (addr from [20:14]), 8 bytes AA..B1, then STOP.
  - Required: `gyro_ready` = 0; `mag_ready` = 1; `mag_data` = 0xAFAEADACABAA.
- Overrun and collision:
  - Stimulus: second acc burst while `acc_ready` = 1.
  - Required: data replaced with new value; `overrun[0]` = 1.
  - Stimulus: a later commit coinciding with an `acc_read` pulse.
  - Required: ready stays 1.
- Reset mid-frame:
  - Stimulus: assert `n_rst` low after 2 data bytes, release, finish the bus bytes, then STOP.
  - Required: no commit; all outputs 0.

Source files
------------

// File: rtl/i2c_sensor_capture.sv
// Passive I2C monitor: captures 6-byte read bursts from three sensors into
// 48-bit holding registers and exposes each one through a ready/read handshake.
module i2c_sensor_capture (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        scl,
  input  logic        sda_in,
  input  logic [20:0] device_addr,
  input  logic        acc_read,
  input  logic        gyro_read,
  input  logic        mag_read,
  output logic        acc_ready,
  output logic        gyro_ready,
  output logic        mag_ready,
  output logic [47:0] acc_data,
  output logic [47:0] gyro_data,
  output logic [47:0] mag_data,
  output logic [2:0]  overrun
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_IGNORE = 2'd3;

  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic [1:0] settle_cnt;
  logic       settled;
  logic       scl_rise_q, start_q, stop_q;

  logic [1:0]  state;
  logic [3:0]  bit_cnt;
  logic [6:0]  shift_reg;
  logic [2:0]  byte_idx;
  logic [47:0] buffer;
  logic [2:0]  sel_oh;
  logic        addr_hit;

  logic [2:0]  hit_vec;
  logic [2:0]  commit_vec;
  logic [2:0]  read_vec;
  logic [2:0]  ready_q;
  logic [47:0] data_q [3];

  // Edge detection is suppressed until the sync and history flops all hold
  // real bus samples, so reset values can never masquerade as START/STOP.
  assign settled = (settle_cnt == 2'd3);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_s1     <= 1'b1;
      scl_s2     <= 1'b1;
      scl_h      <= 1'b1;
      sda_s1     <= 1'b1;
      sda_s2     <= 1'b1;
      sda_h      <= 1'b1;
      settle_cnt <= 2'd0;
      scl_rise_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_s1     <= scl;
      scl_s2     <= scl_s1;
      scl_h      <= scl_s2;
      sda_s1     <= sda_in;
      sda_s2     <= sda_s1;
      sda_h      <= sda_s2;
      if (!settled) settle_cnt <= settle_cnt + 2'd1;
      scl_rise_q <= settled & scl_s2 & ~scl_h;
      start_q    <= settled & scl_s2 & ~sda_s2 & sda_h;
      stop_q     <= settled & scl_s2 & sda_s2 & ~sda_h;
    end
  end

  // Address byte = {shift_reg, sda_h}: shift_reg holds addr[6:0], sda_h is rw.
  always_comb begin
    hit_vec[0] = (shift_reg == device_addr[6:0]);
    hit_vec[1] = (shift_reg == device_addr[13:7]);
    hit_vec[2] = (shift_reg == device_addr[20:14]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift_reg <= 7'd0;
      byte_idx  <= 3'd0;
      buffer    <= 48'd0;
      sel_oh    <= 3'b000;
      addr_hit  <= 1'b0;
    end else if (start_q) begin
      state    <= ST_ADDR;
      bit_cnt  <= 4'd0;
      byte_idx <= 3'd0;
      buffer   <= 48'd0;
      addr_hit <= 1'b0;
    end else if (stop_q) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt  <= 4'd0;
          byte_idx <= 3'd0;
          buffer   <= 48'd0;
        end
        ST_ADDR: if (scl_rise_q) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            state   <= addr_hit ? ST_DATA : ST_IGNORE;
          end else begin
            shift_reg <= {shift_reg[5:0], sda_h};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              addr_hit <= sda_h & (|hit_vec);
              sel_oh   <= hit_vec[0] ? 3'b001 : hit_vec[1] ? 3'b010 : 3'b100;
            end
          end
        end
        ST_DATA: if (scl_rise_q) begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
          end else begin
            shift_reg <= {shift_reg[5:0], sda_h};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7 && byte_idx != 3'd6) begin
              for (int i = 0; i < 6; i++)
                if (byte_idx == 3'(i)) buffer[8*i +: 8] <= {shift_reg, sda_h};
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: combinational outputs get a default before any condition so no
  // path leaves them unassigned and a latch cannot be inferred.
  always_comb begin
    commit_vec = 3'b000;
    if (stop_q && state == ST_DATA && byte_idx == 3'd6) commit_vec = sel_oh;
  end

  assign read_vec = {mag_read, gyro_read, acc_read};

  // A commit outranks a same-cycle read: the fresh sample must not be lost.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ready_q <= 3'b000;
      overrun <= 3'b000;
      // NOTE: the holding registers are flops visible on the ports, so they
      // are reset explicitly; a RAM-backed store would not be.
      for (int i = 0; i < 3; i++) data_q[i] <= 48'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        ready_q[i] <= commit_vec[i] | (ready_q[i] & ~read_vec[i]);
        overrun[i] <= overrun[i] | (commit_vec[i] & ready_q[i]);
        if (commit_vec[i]) data_q[i] <= buffer;
      end
    end
  end

  assign acc_ready  = ready_q[0];
  assign gyro_ready = ready_q[1];
  assign mag_ready  = ready_q[2];
  assign acc_data   = data_q[0];
  assign gyro_data  = data_q[1];
  assign mag_data   = data_q[2];

endmodule

// File: tb/tb_i2c_sensor_capture.sv
// Bench for i2c_sensor_capture: bus-level driver with a transaction model,
// and a monitor that pops expected commits whenever a holding register updates.
module tb_i2c_sensor_capture;

  localparam int Q = 4;  // clk cycles per quarter of an scl bit

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda_in = 1'b1;
  logic [20:0] device_addr;
  logic        acc_read = 1'b0, gyro_read = 1'b0, mag_read = 1'b0;
  logic        acc_ready, gyro_ready, mag_ready;
  logic [47:0] acc_data, gyro_data, mag_data;
  logic [2:0]  overrun;

  i2c_sensor_capture dut (
    .clk(clk), .n_rst(n_rst), .scl(scl), .sda_in(sda_in),
    .device_addr(device_addr),
    .acc_read(acc_read), .gyro_read(gyro_read), .mag_read(mag_read),
    .acc_ready(acc_ready), .gyro_ready(gyro_ready), .mag_ready(mag_ready),
    .acc_data(acc_data), .gyro_data(gyro_data), .mag_data(mag_data),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          sensor;
    logic [47:0] data;
    int unsigned cyc;
    logic [2:0]  ovr;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [2:0]  ready_m = 3'b000;
  logic [2:0]  ovr_m   = 3'b000;
  logic [47:0] data_m [3] = '{48'd0, 48'd0, 48'd0};

  logic [2:0]  dut_ready;
  logic [47:0] dut_data [3];
  assign dut_ready   = {mag_ready, gyro_ready, acc_ready};
  assign dut_data[0] = acc_data;
  assign dut_data[1] = gyro_data;
  assign dut_data[2] = mag_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_read(input int s, input logic v);
    case (s)
      0: acc_read = v;
      1: gyro_read = v;
      default: mag_read = v;
    endcase
  endtask

  // Which sensor a header addresses, acc first, or -1 if none.
  function automatic int target(input logic [6:0] a, input bit rw);
    if (!rw) return -1;
    if (a == device_addr[6:0])   return 0;
    if (a == device_addr[13:7])  return 1;
    if (a == device_addr[20:14]) return 2;
    return -1;
  endfunction

  task automatic bus_start();
    sda_in = 1'b1; clks(Q);
    scl    = 1'b1; clks(Q);
    sda_in = 1'b0; clks(Q);
    scl    = 1'b0; clks(Q);
  endtask

  task automatic bus_bit(input logic b);
    sda_in = b;    clks(Q);
    scl    = 1'b1; clks(Q);
    scl    = 1'b0; clks(Q);
  endtask

  task automatic bus_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_bit(1'b0);
  endtask

  // STOP; on a valid frame the commit is modelled and its expected edge queued.
  task automatic bus_stop(input bit commit, input int s, input logic [47:0] d, input int collide);
    sda_in = 1'b0; clks(Q);
    scl    = 1'b1; clks(Q);
    sda_in = 1'b1;
    if (commit) begin
      if (ready_m[s]) ovr_m[s] = 1'b1;
      ready_m[s] = 1'b1;
      data_m[s]  = d;
      exp_q.push_back('{s, d, cyc + 4, ovr_m});
    end
    if (collide >= 0) begin
      clks(3);
      set_read(collide, 1'b1);
      clks(1);
      set_read(collide, 1'b0);
      if (!(commit && s == collide)) ready_m[collide] = 1'b0;
      clks(Q + 2);
    end else begin
      clks(Q + 4);
    end
  endtask

  task automatic burst(input logic [6:0] addr, input bit rw, input int n,
                       input bit with_stop, input int collide, input logic [63:0] bytes);
    int t;
    bus_start();
    bus_byte({addr, rw});
    for (int i = 0; i < n; i++) bus_byte(bytes[8*i +: 8]);
    t = target(addr, rw);
    if (with_stop) bus_stop(t >= 0 && n >= 6, t, bytes[47:0], collide);
  endtask

  task automatic read_pulse(input int s);
    set_read(s, 1'b1);
    clks(1);
    set_read(s, 1'b0);
    ready_m[s] = 1'b0;
    check($sformatf("read%0d_ready", s), dut_ready, ready_m);
    check($sformatf("read%0d_data", s), dut_data[s], data_m[s]);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ready"}, dut_ready, ready_m);
    check({tag, "_overrun"}, overrun, ovr_m);
    for (int s = 0; s < 3; s++) check($sformatf("%s_data%0d", tag, s), dut_data[s], data_m[s]);
  endtask

  // Monitor: any ready rise, data change or overrun rise is a commit.
  initial begin
    logic [2:0]  prev_ready;
    logic [2:0]  prev_ovr;
    logic [47:0] prev_data [3];
    exp_t        e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        for (int s = 0; s < 3; s++) begin
          if ((dut_ready[s] && !prev_ready[s]) || dut_data[s] !== prev_data[s] ||
              (overrun[s] && !prev_ovr[s])) begin
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL unexpected_commit: sensor %0d data %0h at cycle %0d, required no commit",
                       s, dut_data[s], cyc);
            end else begin
              e = exp_q.pop_front();
              check("commit_sensor", s, e.sensor);
              check("commit_data", dut_data[s], e.data);
              check("commit_cycle", cyc, e.cyc);
              check("commit_ready", dut_ready[s], 1'b1);
              check("commit_overrun", overrun, e.ovr);
            end
          end
        end
      end
      prev_ready = dut_ready;
      prev_ovr   = overrun;
      for (int s = 0; s < 3; s++) prev_data[s] = dut_data[s];
    end
  end

  initial begin
    logic [63:0] rnd;
    logic [6:0]  ua;
    int          kind;
    bit          rw;
    bit          stop;
    int          n;

    device_addr = {7'h1E, 7'h6B, 7'h68};
    clks(3);
    check_state("reset");
    n_rst = 1'b1;
    clks(4);

    // Single accelerometer commit
    burst(7'h68, 1'b1, 6, 1'b1, -1, 64'h0000_0605_0403_0201);
    check_state("single");
    check("single_acc_data", acc_data, 48'h0605_0403_0201);

    // Handshake, including a read of an empty sensor
    read_pulse(0);
    read_pulse(1);

    // Filtering: unknown address, write direction, short burst
    burst(7'h50, 1'b1, 6, 1'b1, -1, {$urandom, $urandom});
    burst(7'h68, 1'b0, 6, 1'b1, -1, {$urandom, $urandom});
    burst(7'h68, 1'b1, 4, 1'b1, -1, {$urandom, $urandom});
    check_state("filter");

    // Repeated start aborts gyro; over-length mag burst keeps first six bytes
    burst(7'h6B, 1'b1, 3, 1'b0, -1, {$urandom, $urandom});
    burst(7'h1E, 1'b1, 8, 1'b1, -1, 64'hB1B0_AFAE_ADAC_ABAA);
    check_state("restart");
    check("restart_mag_data", mag_data, 48'hAFAE_ADAC_ABAA);

    // Overrun, then a commit colliding with a read of the same sensor
    burst(7'h68, 1'b1, 6, 1'b1, -1, {$urandom, $urandom});
    burst(7'h68, 1'b1, 6, 1'b1, -1, {$urandom, $urandom});
    check_state("overrun");
    check("overrun_acc_bit", overrun[0], 1'b1);
    burst(7'h68, 1'b1, 6, 1'b1, 0, {$urandom, $urandom});
    check_state("collide");
    check("collide_acc_ready", acc_ready, 1'b1);

    // Address priority when fields coincide
    device_addr = {7'h1E, 7'h68, 7'h68};
    burst(7'h68, 1'b1, 6, 1'b1, -1, {$urandom, $urandom});
    check_state("prio_acc");
    device_addr = {7'h55, 7'h55, 7'h1E};
    burst(7'h55, 1'b1, 6, 1'b1, -1, {$urandom, $urandom});
    check_state("prio_gyro");
    device_addr = {7'h1E, 7'h6B, 7'h68};

    // Randomised traffic
    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 3));
      rw   = ($urandom_range(0, 3) != 0);
      n    = int'($urandom_range(4, 8));
      stop = (it == 23) || ($urandom_range(0, 5) != 0);
      rnd  = {$urandom, $urandom};
      case (kind)
        0: ua = device_addr[6:0];
        1: ua = device_addr[13:7];
        2: ua = device_addr[20:14];
        default: begin
          do ua = 7'($urandom_range(0, 127));
          while (ua == device_addr[6:0] || ua == device_addr[13:7] || ua == device_addr[20:14]);
        end
      endcase
      burst(ua, rw, n, stop, -1, rnd);
      if (stop) begin
        check_state($sformatf("rand%0d", it));
        for (int s = 0; s < 3; s++) if ($urandom_range(0, 1) == 1) read_pulse(s);
      end
    end

    // Reset in the middle of a valid burst
    bus_start();
    bus_byte({7'h68, 1'b1});
    bus_byte(8'h11);
    bus_byte(8'h22);
    n_rst = 1'b0;
    clks(3);
    n_rst = 1'b1;
    ready_m = 3'b000;
    ovr_m   = 3'b000;
    for (int s = 0; s < 3; s++) data_m[s] = 48'd0;
    clks(2);
    for (int i = 0; i < 4; i++) bus_byte(8'(8'h33 + i));
    bus_stop(1'b0, 0, 48'd0, -1);
    check_state("midreset");

    clks(10);
    check("pending_commits", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
